alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
Command sequencer between the system controller and the ALU function units (arithmetic, logic, compare, shift). It accepts one ALU command through a valid/ready handshake and registers the operands. It decodes the 4-bit function code into a one-hot unit enable plus a 2-bit sub-function. It then waits for the selected unit's completion flag, captures that unit's result and returns it through a valid/ready response interface, with a timeout guard.

Parameters:
IN_WIDTH, 16, operand width
RES_WIDTH, 17, unit result width (IN_WIDTH+1)
TIMEOUT, 8, max EXEC cycles to wait for unit flag; legal range ≥2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command
cmd_fun  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] sub-function
cmd_a  in  IN_WIDTH  operand A
cmd_b  in  IN_WIDTH  operand B
op_a  out  IN_WIDTH  registered operand A to all units
op_b  out  IN_WIDTH  registered operand B to all units
alu_fun_sub  out  2  registered sub-function to all units
arith_en, logic_en, cmp_en, shift_en  out  1 each  unit enables, at most one high
arith_out, logic_out, cmp_out, shift_out  in  RES_WIDTH each  unit results
arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  unit result-valid flags
res_data  out  RES_WIDTH  captured result
res_err  out  1  result is a timeout abort
res_valid  out  1  response present
res_ready  in  1  consumer accepts response

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state IDLE; op_a, op_b, alu_fun_sub = 0; all enables 0; res_data = 0, res_err = 0, res_valid = 0; timeout counter 0.
- cmd_ready = (state==IDLE), decoded from the state register; no combinational path from any input.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - On an edge with cmd_valid=1 (accept edge E0), latch cmd_a → op_a, cmd_b → op_b, cmd_fun[1:0] → alu_fun_sub.
  - Set the enable selected by cmd_fun[3:2], clear the counter, go to EXEC.
  - cmd_valid=0: hold all state.
- EXEC:
  - Selected enable held high; op_a, op_b and alu_fun_sub stable.
  - Only the selected unit's flag is observed; the other three flags are ignored.
  - Selected flag = 1 at an edge: capture the selected unit's output into res_data, res_err=0, drop the enable, res_valid=1, go to RESP.
  - Flag = 0 and counter == TIMEOUT-1: res_data=0, res_err=1, drop the enable, res_valid=1, go to RESP.
  - Otherwise the counter increments.
  - Flag and timeout at the same edge: the flag wins, and the normal result is captured.
- Normal latency: unit registers at E1, flag is sampled at E2, res_valid high after E2 (2 cycles after the accept edge). The enable is high for exactly 2 cycles.
- Timeout latency: res_valid rises after edge E_TIMEOUT.
- RESP:
  - res_valid=1; res_data and res_err held.
  - On an edge with res_ready=1: res_valid=0, go to IDLE.
  - cmd_valid is ignored in RESP (cmd_ready=0).
  - Minimum command-to-command spacing is 3 edges (IDLE → EXEC → RESP → IDLE) with res_ready held high.
- Results are not modified: width RES_WIDTH pass-through, no sign extension or truncation.
- Reset mid-EXEC or mid-RESP: abort at that edge. Enables drop, no response is produced, and the pending result is discarded.
- No command queuing: one outstanding operation at a time.

Test Plan:
- Reset, then idle: cmd_ready=1, all enables, res_valid, res_data and res_err = 0.
- Logic AND: cmd_fun=4'b0100, cmd_a=16'h00F0, cmd_b=16'h0FF0, unit model flags 1 cycle after enable.
  - logic_en high exactly 2 cycles, alu_fun_sub=2'b00.
  - res_valid 2 cycles after accept, res_data=17'h000F0, res_err=0.
- Backpressure: same op with res_ready=0 for 5 cycles.
  - res_valid and res_data held stable, cmd_ready=0.
  - A cmd_valid pulse during this window is not accepted.
  - res_ready=1 → IDLE next cycle.
- Timeout: cmd_fun=4'b1100, shift_flag tied 0, TIMEOUT=8.
  - shift_en high 8 cycles.
  - res_valid after the 8th edge, res_err=1, res_data=0.
- Cross-flag isolation plus collision:
  - Logic op with cmp_flag=1 throughout: no early completion.
  - Separately, TIMEOUT=2 with flag arriving at E2: normal result, res_err=0.
- Reset mid-EXEC: rst=1 one cycle after accept.
  - Enable low next cycle, no res_valid, cmd_ready=1.
  - A following command completes normally.

Source files
------------

// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - command/response handshake bundle for alu_dispatch
// Controller side is the master; the dispatcher is the slave.
interface alu_dispatch_if #(
  parameter int IN_WIDTH  = 16,
  parameter int RES_WIDTH = 17
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_fun;
  logic [IN_WIDTH-1:0]  cmd_a;
  logic [IN_WIDTH-1:0]  cmd_b;
  logic [RES_WIDTH-1:0] res_data;
  logic                 res_err;
  logic                 res_valid;
  logic                 res_ready;

  modport master (
    output cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_data, res_err, res_valid
  );

  modport slave (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_data, res_err, res_valid
  );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - single-outstanding ALU command sequencer with timeout guard
// Accepts a command, enables one function unit, waits for its flag and returns the result.
module alu_dispatch #(
  parameter int IN_WIDTH  = 16,
  parameter int RES_WIDTH = 17,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_dispatch_if.slave        bus,
  output logic [IN_WIDTH-1:0]  o_op_a,
  output logic [IN_WIDTH-1:0]  o_op_b,
  output logic [1:0]           o_alu_fun_sub,
  output logic                 o_arith_en,
  output logic                 o_logic_en,
  output logic                 o_cmp_en,
  output logic                 o_shift_en,
  input  logic [RES_WIDTH-1:0] i_arith_out,
  input  logic [RES_WIDTH-1:0] i_logic_out,
  input  logic [RES_WIDTH-1:0] i_cmp_out,
  input  logic [RES_WIDTH-1:0] i_shift_out,
  input  logic                 i_arith_flag,
  input  logic                 i_logic_flag,
  input  logic                 i_cmp_flag,
  input  logic                 i_shift_flag
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t               r_state, w_state;
  logic [IN_WIDTH-1:0]  r_op_a, w_op_a;
  logic [IN_WIDTH-1:0]  r_op_b, w_op_b;
  logic [1:0]           r_fun_sub, w_fun_sub;
  logic [1:0]           r_sel, w_sel;
  logic [3:0]           r_en, w_en;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [RES_WIDTH-1:0] r_res_data, w_res_data;
  logic                 r_res_err, w_res_err;
  logic                 r_res_valid, w_res_valid;
  logic                 w_flag;
  logic [RES_WIDTH-1:0] w_unit_out;

  // Only the unit chosen at accept time is observed; stray flags are ignored.
  always_comb begin
    w_flag     = 1'b0;
    w_unit_out = '0;
    case (r_sel)
      2'd0: begin w_flag = i_arith_flag; w_unit_out = i_arith_out; end
      2'd1: begin w_flag = i_logic_flag; w_unit_out = i_logic_out; end
      2'd2: begin w_flag = i_cmp_flag;   w_unit_out = i_cmp_out;   end
      default: begin w_flag = i_shift_flag; w_unit_out = i_shift_out; end
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_op_a      = r_op_a;
    w_op_b      = r_op_b;
    w_fun_sub   = r_fun_sub;
    w_sel       = r_sel;
    w_en        = r_en;
    w_cnt       = r_cnt;
    w_res_data  = r_res_data;
    w_res_err   = r_res_err;
    w_res_valid = r_res_valid;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_op_a    = bus.cmd_a;
          w_op_b    = bus.cmd_b;
          w_fun_sub = bus.cmd_fun[1:0];
          w_sel     = bus.cmd_fun[3:2];
          w_en      = 4'b0001 << bus.cmd_fun[3:2];
          w_cnt     = '0;
          w_state   = S_EXEC;
        end
      end
      S_EXEC: begin
        // Flag is tested first so a flag on the last allowed edge still completes.
        if (w_flag) begin
          w_res_data  = w_unit_out;
          w_res_err   = 1'b0;
          w_en        = '0;
          w_res_valid = 1'b1;
          w_state     = S_RESP;
        end else if (r_cnt == LAST) begin
          w_res_data  = '0;
          w_res_err   = 1'b1;
          w_en        = '0;
          w_res_valid = 1'b1;
          w_state     = S_RESP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          w_res_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_fun_sub   <= '0;
      r_sel       <= '0;
      r_en        <= '0;
      r_cnt       <= '0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_op_a      <= w_op_a;
      r_op_b      <= w_op_b;
      r_fun_sub   <= w_fun_sub;
      r_sel       <= w_sel;
      r_en        <= w_en;
      r_cnt       <= w_cnt;
      r_res_data  <= w_res_data;
      r_res_err   <= w_res_err;
      r_res_valid <= w_res_valid;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.res_data  = r_res_data;
  assign bus.res_err   = r_res_err;
  assign bus.res_valid = r_res_valid;
  assign o_op_a        = r_op_a;
  assign o_op_b        = r_op_b;
  assign o_alu_fun_sub = r_fun_sub;
  assign o_arith_en    = r_en[0];
  assign o_logic_en    = r_en[1];
  assign o_cmp_en      = r_en[2];
  assign o_shift_en    = r_en[3];
endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed self-checking bench for alu_dispatch
// Two instances: TIMEOUT=8 for the main plan and TIMEOUT=2 for the flag/timeout collision.
module tb_alu_dispatch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  alu_dispatch_if #(.IN_WIDTH(16), .RES_WIDTH(17)) bus1 ();
  alu_dispatch_if #(.IN_WIDTH(16), .RES_WIDTH(17)) bus2 ();

  logic [15:0] op_a1, op_b1, op_a2, op_b2;
  logic [1:0]  sub1, sub2;
  logic        a_en1, l_en1, c_en1, s_en1;
  logic        a_en2, l_en2, c_en2, s_en2;
  logic [3:0]  u_flag;
  logic [16:0] u_out [4];
  logic [3:0]  kill, frc;
  logic        u2_flag;
  logic [16:0] u2_out;
  logic [3:0]  en1;
  assign en1 = {s_en1, c_en1, l_en1, a_en1};

  // Registered unit models: flag follows enable one edge later.
  always @(posedge clk) begin
    u_flag   <= (en1 & ~kill) | frc;
    u_out[0] <= {1'b0, op_a1} + {1'b0, op_b1};
    u_out[1] <= {1'b0, (sub1 == 2'd0) ? (op_a1 & op_b1) :
                       (sub1 == 2'd1) ? (op_a1 | op_b1) : (op_a1 ^ op_b1)};
    u_out[2] <= {16'b0, op_a1 < op_b1};
    u_out[3] <= {1'b0, op_a1 << op_b1[3:0]};
    u2_flag  <= a_en2;
    u2_out   <= {1'b0, op_a2} + {1'b0, op_b2};
  end

  alu_dispatch #(.IN_WIDTH(16), .RES_WIDTH(17), .TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .o_op_a(op_a1), .o_op_b(op_b1), .o_alu_fun_sub(sub1),
    .o_arith_en(a_en1), .o_logic_en(l_en1), .o_cmp_en(c_en1), .o_shift_en(s_en1),
    .i_arith_out(u_out[0]), .i_logic_out(u_out[1]), .i_cmp_out(u_out[2]), .i_shift_out(u_out[3]),
    .i_arith_flag(u_flag[0]), .i_logic_flag(u_flag[1]), .i_cmp_flag(u_flag[2]), .i_shift_flag(u_flag[3])
  );

  alu_dispatch #(.IN_WIDTH(16), .RES_WIDTH(17), .TIMEOUT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .o_op_a(op_a2), .o_op_b(op_b2), .o_alu_fun_sub(sub2),
    .o_arith_en(a_en2), .o_logic_en(l_en2), .o_cmp_en(c_en2), .o_shift_en(s_en2),
    .i_arith_out(u2_out), .i_logic_out(17'h0), .i_cmp_out(17'h0), .i_shift_out(17'h0),
    .i_arith_flag(u2_flag), .i_logic_flag(1'b0), .i_cmp_flag(1'b0), .i_shift_flag(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue1(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    bus1.cmd_valid = 1'b1;
    bus1.cmd_fun   = fun;
    bus1.cmd_a     = a;
    bus1.cmd_b     = b;
    tick();
    bus1.cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    kill = 4'b0; frc = 4'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_fun = 4'h0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.res_ready = 1'b1;
    bus2.cmd_valid = 1'b0; bus2.cmd_fun = 4'h0; bus2.cmd_a = '0; bus2.cmd_b = '0; bus2.res_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_ready", bus1.cmd_ready, 1);
    chk("rst_en", en1, 0);
    chk("rst_valid", bus1.res_valid, 0);
    chk("rst_data", bus1.res_data, 0);
    chk("rst_err", bus1.res_err, 0);

    // Logic AND: enable for exactly two cycles, response two edges after accept
    issue1(4'b0100, 16'h00F0, 16'h0FF0);
    chk("and_en_c1", en1, 4'b0010);
    chk("and_sub", sub1, 2'b00);
    chk("and_ready_busy", bus1.cmd_ready, 0);
    chk("and_valid_c1", bus1.res_valid, 0);
    tick();
    chk("and_en_c2", en1, 4'b0010);
    chk("and_valid_c2", bus1.res_valid, 0);
    tick();
    chk("and_valid", bus1.res_valid, 1);
    chk("and_data", bus1.res_data, 17'h000F0);
    chk("and_err", bus1.res_err, 0);
    chk("and_en_off", en1, 0);
    tick();
    chk("and_done_valid", bus1.res_valid, 0);
    chk("and_done_ready", bus1.cmd_ready, 1);

    // Backpressure with an ignored command pulse in RESP
    bus1.res_ready = 1'b0;
    issue1(4'b0100, 16'h00F0, 16'h0FF0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus1.cmd_valid = 1'b1; bus1.cmd_fun = 4'b0000; bus1.cmd_a = 16'hAAAA;
      end else begin
        bus1.cmd_valid = 1'b0;
      end
      tick();
      chk($sformatf("bp_valid_%0d", i), bus1.res_valid, 1);
      chk($sformatf("bp_data_%0d", i), bus1.res_data, 17'h000F0);
      chk($sformatf("bp_ready_%0d", i), bus1.cmd_ready, 0);
    end
    bus1.cmd_valid = 1'b0;
    bus1.res_ready = 1'b1;
    tick();
    chk("bp_rel_valid", bus1.res_valid, 0);
    chk("bp_rel_ready", bus1.cmd_ready, 1);
    chk("bp_no_accept_en", en1, 0);
    chk("bp_no_accept_a", op_a1, 16'h00F0);

    // Timeout on shift unit: enable high for 8 cycles, error response after 8th edge
    kill = 4'b1000;
    issue1(4'b1100, 16'h0001, 16'h0001);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("to_en_%0d", i), en1, 4'b1000);
      chk($sformatf("to_valid_%0d", i), bus1.res_valid, 0);
      tick();
    end
    chk("to_valid", bus1.res_valid, 1);
    chk("to_err", bus1.res_err, 1);
    chk("to_data", bus1.res_data, 0);
    chk("to_en_off", en1, 0);
    tick();
    kill = 4'b0000;
    chk("to_idle", bus1.cmd_ready, 1);

    // Foreign cmp flag held high must not complete a logic OR early
    frc = 4'b0100;
    issue1(4'b0101, 16'h00F0, 16'h0FF0);
    tick();
    chk("iso_no_early", bus1.res_valid, 0);
    tick();
    chk("iso_valid", bus1.res_valid, 1);
    chk("iso_data", bus1.res_data, 17'h00FF0);
    chk("iso_err", bus1.res_err, 0);
    tick();
    frc = 4'b0000;

    // TIMEOUT=2: flag and timeout on the same edge, flag wins; carry out preserved
    bus2.cmd_valid = 1'b1; bus2.cmd_fun = 4'b0000; bus2.cmd_a = 16'hFFFF; bus2.cmd_b = 16'h0001;
    tick();
    bus2.cmd_valid = 1'b0;
    tick();
    chk("col_wait", bus2.res_valid, 0);
    tick();
    chk("col_valid", bus2.res_valid, 1);
    chk("col_err", bus2.res_err, 0);
    chk("col_data", bus2.res_data, 17'h10000);
    tick();

    // Reset one cycle after accept aborts the operation
    issue1(4'b0100, 16'h00F0, 16'h0FF0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rx_en", en1, 0);
    chk("rx_valid", bus1.res_valid, 0);
    chk("rx_ready", bus1.cmd_ready, 1);
    tick(); tick();
    chk("rx_no_resp", bus1.res_valid, 0);
    issue1(4'b0000, 16'h1234, 16'h4321);
    chk("rx2_en", en1, 4'b0001);
    tick(); tick();
    chk("rx2_valid", bus1.res_valid, 1);
    chk("rx2_data", bus1.res_data, 17'h05555);
    chk("rx2_err", bus1.res_err, 0);
    tick();
    chk("rx2_idle", bus1.cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
